micro_datapath: RTL and testbench
=================================

// Module: micro_datapath
// PURPOSE
//  Execution datapath driven by micro_control. Holds a 16x32 register file, MB/MD/MM muxes and the
//  function unit (ALU + shifter). It drives data-memory address, write data and write enable, and
//  returns registered N/Z/V/C status flags to the control unit's flag mux (mux_s).
//  Register write-back is pipelined one cycle, so synchronous (BRAM) memory read data is written cleanly.
// PARAMETERS
//  DATA_W    32  datapath/register width
//  REG_N     16  register count (address width 4)
//  ADDR_W    8   data-memory address width
//  R0_ZERO   1   1: R0 reads 0 and writes to R0 are dropped
// PORTS
//  i_clk        in   1       clock
//  i_rstn       in   1       reset; synchronous, active-low
//  i_dr         in   4       destination register
//  i_sa         in   4       A-bus source register
//  i_sb         in   4       B-bus source register
//  i_fs         in   5       function select
//  i_mb         in   1       0: B = R[sb], 1: B = i_imd
//  i_md         in   1       0: write-back F, 1: write-back i_mem_rdata
//  i_rw         in   1       register write enable
//  i_mm         in   1       0: address = A[ADDR_W-1:0], 1: address = i_pc
//  i_mw         in   1       memory write enable
//  i_imd        in   32      immediate operand
//  i_pc         in   8       program counter from micro_control
//  i_mem_rdata  in   32      data-memory read data (valid 1 cycle after address)
//  o_mem_addr   out  8       data-memory address
//  o_mem_wdata  out  32      data-memory write data (= B bus after MB mux)
//  o_mem_we     out  1       data-memory write enable
//  o_n/o_z/o_v/o_c  out 1 each  registered status flags
// BEHAVIOUR
//  - Cycle t (EX): read A/B, compute F, drive memory combinationally. Edge at end of t: WB stage
//    captures {rw,dr,md,F} and flags capture N/Z/V/C from F. Edge at end of t+1 (WB): R[wb_dr] <=
//    wb_md ? i_mem_rdata : wb_F when wb_rw is set.
//  - Forwarding: when wb_rw is set and wb_dr equals sa (or sb), that operand takes the WB data.
//    When R0_ZERO=1, R0 is excluded from forwarding. An EX-cycle read of the register being written
//    in the same cycle therefore sees the new value.
//  - FS: 00000 F=A; 00001 A+1; 00010 A+B; 00011 A+B+1; 00100 A+~B; 00101 A-B; 00110 A-1;
//    01000 A&B; 01010 A|B; 01100 A^B; 01110 ~A; 10000 F=B; 10100 B>>1 (logical); 11000 B<<1.
//    Any other code: F=A, C=V=0.
//  - Flags: N=F[31]; Z=(F==0). Arithmetic: C=carry-out of the 33-bit sum; V=signed overflow.
//    Logic/move: C=V=0. Shifts: C=bit shifted out, V=0. Flags load every cycle, so a branch on
//    flags goes in the microinstruction after the one that sets them.
//  - Memory: o_mem_addr = i_mm ? i_pc : A[7:0]; o_mem_we = i_mw & i_rstn; no stall, no handshake.
//  - Reset (i_rstn=0 at an edge): all registers, WB stage (wb_rw=0) and flags go to 0.
//    o_mem_we is held 0 while i_rstn is low. A pending write-back is discarded on reset.
//  - Simultaneous events: a WB write and an EX read of the same register forward. A memory write and a
//    load of the same address in consecutive cycles return the BRAM's read-first/write-first data
//    unchanged (no internal bypass).
// STRUCTURE
//  - micro_pkg: FS code localparams, DATA_W/REG_N/ADDR_W defaults, flag bit indices.
//  - Sub-module function_unit: combinational ALU+shifter, inputs {A,B,fs}, outputs {F,n,z,v,c}.
//  - Top holds register file, MB/MD/MM muxes, WB stage, forwarding and flag register.
// TESTING
//  1. Reset: drive rw=1 and mw=1 while i_rstn=0. Check all registers read 0, flags 0, o_mem_we=0.
//  2. Load immediate: mb=1, imd=0x7FFFFFFF, fs=10000, dr=1. Next cycle sa=1, sb via mb=1 imd=1,
//     fs=00010, dr=2. Check R2=0x80000000 via forwarding, then N=1, V=1, C=0, Z=0.
//  3. Subtract equal: R3=R4=5, fs=00101 -> F=0, Z=1, C=1, V=0. fs=00110 on R0 -> F=0xFFFFFFFF, N=1.
//  4. Load: mm=0, A=0x10, md=1, rw=1, dr=5, i_mem_rdata=0xCAFEF00D one cycle later. Check R5=0xCAFEF00D,
//     and the immediately following read of R5 forwards 0xCAFEF00D.
//  5. Store: mm=1, pc=0x22, mw=1, B=R6=0x1234. Check addr=0x22, wdata=0x1234, we=1 that cycle only.
//  6. Shifts and R0: B=0x80000001, fs=11000 -> F=0x00000002, C=1; fs=10100 -> F=0x40000000, C=1.
//     Write dr=0 -> R0 still reads 0.

Source files
------------

// File: rtl/micro_pkg.sv
// Shared definitions for the micro-programmed datapath: default widths, function-select codes
// and the status-flag record handed back to the control unit.
package micro_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_N_DEF  = 16;
    localparam int ADDR_W_DEF = 8;

    // Function-select codes; the top bits group them into arithmetic, logic and shift families
    localparam logic [4:0] FS_MOVA  = 5'b00000;
    localparam logic [4:0] FS_INC   = 5'b00001;
    localparam logic [4:0] FS_ADD   = 5'b00010;
    localparam logic [4:0] FS_ADDC  = 5'b00011;
    localparam logic [4:0] FS_ADDNB = 5'b00100;
    localparam logic [4:0] FS_SUB   = 5'b00101;
    localparam logic [4:0] FS_DEC   = 5'b00110;
    localparam logic [4:0] FS_AND   = 5'b01000;
    localparam logic [4:0] FS_OR    = 5'b01010;
    localparam logic [4:0] FS_XOR   = 5'b01100;
    localparam logic [4:0] FS_NOT   = 5'b01110;
    localparam logic [4:0] FS_MOVB  = 5'b10000;
    localparam logic [4:0] FS_SHR   = 5'b10100;
    localparam logic [4:0] FS_SHL   = 5'b11000;

    // Bit positions of the flags when packed as {n,z,v,c}
    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } flags_t;

endpackage

// File: rtl/micro_datapath_function_unit.sv
// Combinational ALU + single-bit shifter. All arithmetic codes share one adder whose B operand
// and carry-in are selected from fs; N/Z/V/C are derived from the selected result.
module function_unit
    import micro_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        fs,
    output logic [DATA_W-1:0] f,
    output logic              n,
    output logic              z,
    output logic              v,
    output logic              c
);

    logic [DATA_W-1:0] add_b;
    logic              add_cin;
    logic              add_en;
    logic [DATA_W:0]   sum;

    always_comb begin
        add_b   = '0;
        add_cin = 1'b0;
        add_en  = 1'b0;
        case (fs)
            FS_INC:   begin add_en = 1'b1; add_cin = 1'b1; end
            FS_ADD:   begin add_en = 1'b1; add_b = b; end
            FS_ADDC:  begin add_en = 1'b1; add_b = b; add_cin = 1'b1; end
            FS_ADDNB: begin add_en = 1'b1; add_b = ~b; end
            FS_SUB:   begin add_en = 1'b1; add_b = ~b; add_cin = 1'b1; end
            FS_DEC:   begin add_en = 1'b1; add_b = '1; end
            default:  ;
        endcase
    end

    assign sum = {1'b0, a} + {1'b0, add_b} + {{DATA_W{1'b0}}, add_cin};

    always_comb begin
        f = a;
        c = 1'b0;
        v = 1'b0;
        if (add_en) begin
            f = sum[DATA_W-1:0];
            c = sum[DATA_W];
            // Overflow: operands agree in sign but the result does not
            v = (a[DATA_W-1] == add_b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
        end else begin
            case (fs)
                FS_AND:  f = a & b;
                FS_OR:   f = a | b;
                FS_XOR:  f = a ^ b;
                FS_NOT:  f = ~a;
                FS_MOVB: f = b;
                FS_SHR:  begin f = {1'b0, b[DATA_W-1:1]}; c = b[0]; end
                FS_SHL:  begin f = {b[DATA_W-2:0], 1'b0}; c = b[DATA_W-1]; end
                default: f = a;
            endcase
        end
    end

    assign n = f[DATA_W-1];
    assign z = (f == '0);

endmodule

// File: rtl/micro_datapath.sv
// Execution datapath: register file with one-cycle write-back stage and forwarding, operand and
// address muxes, function unit and registered N/Z/V/C flags for the control unit.
module micro_datapath
    import micro_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_N   = REG_N_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic [$clog2(REG_N)-1:0] i_dr,
    input  logic [$clog2(REG_N)-1:0] i_sa,
    input  logic [$clog2(REG_N)-1:0] i_sb,
    input  logic [4:0]               i_fs,
    input  logic                     i_mb,
    input  logic                     i_md,
    input  logic                     i_rw,
    input  logic                     i_mm,
    input  logic                     i_mw,
    input  logic [DATA_W-1:0]        i_imd,
    input  logic [ADDR_W-1:0]        i_pc,
    input  logic [DATA_W-1:0]        i_mem_rdata,
    output logic [ADDR_W-1:0]        o_mem_addr,
    output logic [DATA_W-1:0]        o_mem_wdata,
    output logic                     o_mem_we,
    output logic                     o_n,
    output logic                     o_z,
    output logic                     o_v,
    output logic                     o_c
);

    localparam int RA_W = $clog2(REG_N);

    typedef struct packed {
        logic              rw;
        logic [RA_W-1:0]   dr;
        logic              md;
        logic [DATA_W-1:0] f;
    } wb_t;

    wb_t               wb_reg, wb_next;
    flags_t            flags_reg, flags_next;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] rf_rd [REG_N];
    logic [DATA_W-1:0] a_bus, b_reg_val, b_bus, fu_f;
    logic              fwd_a, fwd_b;
    logic              fu_n, fu_z, fu_v, fu_c;

    // Load data arrives from the BRAM during the WB cycle, so it is selected here, not in EX
    assign wb_data = wb_reg.md ? i_mem_rdata : wb_reg.f;

    generate
        for (genvar gi = 0; gi < REG_N; gi++) begin : g_rf
            if (R0_ZERO && gi == 0) begin : g_zero
                assign rf_rd[gi] = '0;
            end else begin : g_reg
                logic [DATA_W-1:0] q_reg;
                always_ff @(posedge i_clk) begin
                    if (!i_rstn) begin
                        q_reg <= '0;
                    end else if (wb_reg.rw && wb_reg.dr == RA_W'(gi)) begin
                        q_reg <= wb_data;
                    end
                end
                assign rf_rd[gi] = q_reg;
            end
        end
    endgenerate

    // A register retiring this cycle is read through the bypass so EX never sees stale data
    assign fwd_a = wb_reg.rw && (wb_reg.dr == i_sa) && !(R0_ZERO && i_sa == '0);
    assign fwd_b = wb_reg.rw && (wb_reg.dr == i_sb) && !(R0_ZERO && i_sb == '0);

    assign a_bus     = fwd_a ? wb_data : rf_rd[i_sa];
    assign b_reg_val = fwd_b ? wb_data : rf_rd[i_sb];
    assign b_bus     = i_mb ? i_imd : b_reg_val;

    function_unit #(
        .DATA_W (DATA_W)
    ) u_fu (
        .a  (a_bus),
        .b  (b_bus),
        .fs (i_fs),
        .f  (fu_f),
        .n  (fu_n),
        .z  (fu_z),
        .v  (fu_v),
        .c  (fu_c)
    );

    always_comb begin
        wb_next    = '{rw: i_rw, dr: i_dr, md: i_md, f: fu_f};
        flags_next = '{n: fu_n, z: fu_z, v: fu_v, c: fu_c};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            wb_reg    <= '0;
            flags_reg <= '0;
        end else begin
            wb_reg    <= wb_next;
            flags_reg <= flags_next;
        end
    end

    assign o_mem_addr  = i_mm ? i_pc : a_bus[ADDR_W-1:0];
    assign o_mem_wdata = b_bus;
    assign o_mem_we    = i_mw & i_rstn;

    assign o_n = flags_reg.n;
    assign o_z = flags_reg.z;
    assign o_v = flags_reg.v;
    assign o_c = flags_reg.c;

endmodule

// File: tb/tb_micro_datapath.sv
// Table-driven bench for micro_datapath: memory-side outputs checked mid-cycle, flag results
// queued on the scoreboard when an operation is driven and compared after the capturing edge.
module tb_micro_datapath;
    import micro_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic [3:0]  i_dr, i_sa, i_sb;
    logic [4:0]  i_fs;
    logic        i_mb, i_md, i_rw, i_mm, i_mw;
    logic [31:0] i_imd;
    logic [7:0]  i_pc;
    logic [31:0] i_mem_rdata;
    logic [7:0]  o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        o_mem_we;
    logic        o_n, o_z, o_v, o_c;

    always #5 i_clk = ~i_clk;

    micro_datapath dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_dr        (i_dr),
        .i_sa        (i_sa),
        .i_sb        (i_sb),
        .i_fs        (i_fs),
        .i_mb        (i_mb),
        .i_md        (i_md),
        .i_rw        (i_rw),
        .i_mm        (i_mm),
        .i_mw        (i_mw),
        .i_imd       (i_imd),
        .i_pc        (i_pc),
        .i_mem_rdata (i_mem_rdata),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_we    (o_mem_we),
        .o_n         (o_n),
        .o_z         (o_z),
        .o_v         (o_v),
        .o_c         (o_c)
    );

    typedef struct {
        logic [3:0]  dr, sa, sb;
        logic [4:0]  fs;
        logic        mb, md, rw, mm, mw;
        logic [31:0] imd;
        logic [7:0]  pc;
        logic [31:0] rdata;
        logic        chk_mem;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        we;
        logic        chk_flg;
        logic [3:0]  nzvc;
    } vec_t;

    typedef struct {
        string      tag;
        logic [3:0] nzvc;
    } flag_exp_t;

    localparam int NV = 31;
    vec_t      tbl [NV];
    flag_exp_t flag_q [$];
    int        errors = 0;
    int        checks = 0;

    function automatic vec_t mk(input logic [3:0] dr, input logic [3:0] sa, input logic [3:0] sb,
                                input logic [4:0] fs, input logic mb, input logic md, input logic rw,
                                input logic mm, input logic mw, input logic [31:0] imd,
                                input logic [7:0] pc, input logic [31:0] rdata, input logic [7:0] addr,
                                input logic [31:0] wdata, input logic we, input logic [3:0] nzvc);
        vec_t v;
        v.dr = dr; v.sa = sa; v.sb = sb; v.fs = fs;
        v.mb = mb; v.md = md; v.rw = rw; v.mm = mm; v.mw = mw;
        v.imd = imd; v.pc = pc; v.rdata = rdata;
        v.chk_mem = 1'b1; v.addr = addr; v.wdata = wdata; v.we = we;
        v.chk_flg = 1'b1; v.nzvc = nzvc;
        return v;
    endfunction

    // Read register r onto the B bus (observed as write data); F = R0 = 0 so Z is expected
    function automatic vec_t rd(input logic [3:0] r, input logic [31:0] exp);
        return mk(4'd0, 4'd0, r, FS_MOVA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00, 32'h0,
                  8'h00, exp, 1'b0, 4'b0100);
    endfunction

    // Reset cycle with write strobes asserted: nothing may reach memory, flags must clear
    function automatic vec_t rst_vec();
        vec_t v;
        v = mk(4'd1, 4'd0, 4'd0, FS_MOVB, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 8'h00, 32'h0,
               8'h00, 32'h0, 1'b0, 4'b0000);
        v.chk_mem = 1'b0;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input string tag, input vec_t v);
        flag_exp_t   fe;
        logic [7:0]  s_addr;
        logic [31:0] s_wdata;
        logic        s_we;
        i_dr = v.dr; i_sa = v.sa; i_sb = v.sb; i_fs = v.fs;
        i_mb = v.mb; i_md = v.md; i_rw = v.rw; i_mm = v.mm; i_mw = v.mw;
        i_imd = v.imd; i_pc = v.pc; i_mem_rdata = v.rdata;
        @(negedge i_clk);
        s_addr = o_mem_addr; s_wdata = o_mem_wdata; s_we = o_mem_we;
        check({tag, " we"}, 32'(s_we), 32'(v.we));
        if (v.chk_mem) begin
            check({tag, " addr"}, 32'(s_addr), 32'(v.addr));
            check({tag, " wdata"}, s_wdata, v.wdata);
        end
        if (v.chk_flg) begin
            fe.tag = tag;
            fe.nzvc = v.nzvc;
            flag_q.push_back(fe);
        end
        @(posedge i_clk);
        #1;
        if (flag_q.size() > 0) begin
            fe = flag_q.pop_front();
            check({fe.tag, " nzvc"}, 32'({o_n, o_z, o_v, o_c}), 32'(fe.nzvc));
        end
        $display("%s: rstn=%b dr=%0d sa=%0d sb=%0d fs=%b addr=%h wdata=%h we=%b nzvc=%b",
                 tag, i_rstn, v.dr, v.sa, v.sb, v.fs, s_addr, s_wdata, s_we, {o_n, o_z, o_v, o_c});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            dr     sa     sb     fs        mb    md    rw    mm    mw    imd            pc     rdata          addr   wdata          we    nzvc
        tbl[0]  = mk(4'd1, 4'd0, 4'd0, FS_MOVB,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h7FFF_FFFF, 8'h00, 32'h0,         8'h00, 32'h7FFF_FFFF, 1'b0, 4'b0000);
        tbl[1]  = mk(4'd2, 4'd1, 4'd0, FS_ADD,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1,         8'h00, 32'h0,         8'hFF, 32'h1,         1'b0, 4'b1010);
        tbl[2]  = mk(4'd0, 4'd1, 4'd2, FS_MOVB,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         8'h00, 32'h0,         8'hFF, 32'h8000_0000, 1'b0, 4'b1000);
        tbl[3]  = mk(4'd3, 4'd0, 4'd0, FS_MOVB,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h5,         8'h00, 32'h0,         8'h00, 32'h5,         1'b0, 4'b0000);
        tbl[4]  = mk(4'd4, 4'd0, 4'd0, FS_MOVB,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h5,         8'h00, 32'h0,         8'h00, 32'h5,         1'b0, 4'b0000);
        tbl[5]  = mk(4'd0, 4'd3, 4'd4, FS_SUB,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         8'h00, 32'h0,         8'h05, 32'h5,         1'b0, 4'b0101);
        tbl[6]  = mk(4'd0, 4'd0, 4'd0, FS_DEC,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         8'h00, 32'h0,         8'h00, 32'h0,         1'b0, 4'b1000);
        tbl[7]  = mk(4'd7, 4'd0, 4'd0, FS_MOVB,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10,        8'h00, 32'h0,         8'h00, 32'h10,        1'b0, 4'b0000);
        tbl[8]  = mk(4'd5, 4'd7, 4'd0, FS_MOVA,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         8'h00, 32'h0,         8'h10, 32'h0,         1'b0, 4'b0000);
        tbl[9]  = mk(4'd0, 4'd5, 4'd5, FS_MOVA,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         8'h00, 32'hCAFE_F00D, 8'h0D, 32'hCAFE_F00D, 1'b0, 4'b1000);
        tbl[10] = mk(4'd0, 4'd0, 4'd5, FS_MOVA,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         8'h00, 32'h0,         8'h00, 32'hCAFE_F00D, 1'b0, 4'b0100);
        tbl[11] = mk(4'd6, 4'd0, 4'd0, FS_MOVB,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1234,      8'h00, 32'h0,         8'h00, 32'h1234,      1'b0, 4'b0000);
        tbl[12] = mk(4'd0, 4'd0, 4'd6, FS_MOVB,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,         8'h22, 32'h0,         8'h22, 32'h1234,      1'b1, 4'b0000);
        tbl[13] = mk(4'd0, 4'd0, 4'd6, FS_MOVA,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         8'h22, 32'h0,         8'h22, 32'h1234,      1'b0, 4'b0100);
        tbl[14] = mk(4'd9, 4'd0, 4'd0, FS_MOVB,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0001, 8'h00, 32'h0,         8'h00, 32'h8000_0001, 1'b0, 4'b1000);
        tbl[15] = mk(4'd0, 4'd0, 4'd9, FS_SHL,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         8'h00, 32'h0,         8'h00, 32'h8000_0001, 1'b0, 4'b0001);
        tbl[16] = mk(4'd0, 4'd0, 4'd9, FS_SHR,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         8'h00, 32'h0,         8'h00, 32'h8000_0001, 1'b0, 4'b0001);
        tbl[17] = mk(4'd0, 4'd0, 4'd0, FS_MOVB,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 8'h00, 32'h0,         8'h00, 32'hDEAD_BEEF, 1'b0, 4'b1000);
        tbl[18] = mk(4'd0, 4'd0, 4'd0, FS_MOVB,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         8'h00, 32'h0,         8'h00, 32'h0,         1'b0, 4'b0100);
        tbl[19] = mk(4'd0, 4'd0, 4'd0, FS_MOVB,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         8'h00, 32'h0,         8'h00, 32'h0,         1'b0, 4'b0100);
        tbl[20] = mk(4'd0, 4'd6, 4'd0, FS_AND,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFF,        8'h00, 32'h0,         8'h34, 32'hFF,        1'b0, 4'b0000);
        tbl[21] = mk(4'd0, 4'd6, 4'd0, FS_OR,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFF,        8'h00, 32'h0,         8'h34, 32'hFF,        1'b0, 4'b0000);
        tbl[22] = mk(4'd0, 4'd6, 4'd0, FS_XOR,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFF,        8'h00, 32'h0,         8'h34, 32'hFF,        1'b0, 4'b0000);
        tbl[23] = mk(4'd0, 4'd6, 4'd0, FS_NOT,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFF,        8'h00, 32'h0,         8'h34, 32'hFF,        1'b0, 4'b1000);
        tbl[24] = mk(4'd0, 4'd9, 4'd0, FS_ADDC,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF, 8'h00, 32'h0,         8'h01, 32'h7FFF_FFFF, 1'b0, 4'b0001);
        tbl[25] = mk(4'd0, 4'd6, 4'd0, FS_ADDNB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1234,      8'h00, 32'h0,         8'h34, 32'h1234,      1'b0, 4'b1000);
        tbl[26] = mk(4'd0, 4'd1, 4'd0, FS_INC,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         8'h00, 32'h0,         8'hFF, 32'h0,         1'b0, 4'b1010);
        tbl[27] = mk(4'd0, 4'd9, 4'd0, FS_DEC,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         8'h00, 32'h0,         8'h01, 32'h0,         1'b0, 4'b1001);
        tbl[28] = mk(4'd0, 4'd9, 4'd0, 5'b00111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         8'h00, 32'h0,         8'h01, 32'h0,         1'b0, 4'b1000);
        tbl[29] = mk(4'd0, 4'd0, 4'd0, FS_SUB,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1,         8'h00, 32'h0,         8'h00, 32'h1,         1'b0, 4'b1000);
        tbl[30] = mk(4'd0, 4'd9, 4'd0, FS_ADD,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 8'h00, 32'h0,         8'h01, 32'h8000_0000, 1'b0, 4'b0011);

        i_rstn = 1'b0;
        i_dr = '0; i_sa = '0; i_sb = '0; i_fs = '0;
        i_mb = 1'b0; i_md = 1'b0; i_rw = 1'b0; i_mm = 1'b0; i_mw = 1'b0;
        i_imd = '0; i_pc = '0; i_mem_rdata = '0;
        @(posedge i_clk);
        #1;

        repeat (2) apply("reset", rst_vec());
        i_rstn = 1'b1;
        for (int r = 0; r < 16; r++) apply($sformatf("init_r%0d", r), rd(4'(r), 32'h0));

        for (int i = 0; i < NV; i++) apply($sformatf("vec%0d", i), tbl[i]);

        // Reset while a write-back to R8 is pending: the write must be dropped and all state cleared
        apply("wr_r8", mk(4'd8, 4'd0, 4'd0, FS_MOVB, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h55, 8'h00,
                          32'h0, 8'h00, 32'h55, 1'b0, 4'b0000));
        i_rstn = 1'b0;
        apply("mid_reset", rst_vec());
        i_rstn = 1'b1;
        for (int r = 0; r < 16; r++) apply($sformatf("post_r%0d", r), rd(4'(r), 32'h0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
